// File: rtl/rr_meta_arbiter_if.sv
// Metadata arbiter bundle: N_IN packed requesters in, one registered winner out.
// "master" drives requests and the downstream ready; "slave" is the arbiter.
interface rr_meta_arbiter_if #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 6,
  parameter int WAY_W = 4,
  parameter int TAG_W = 20,
  parameter int COH_W = 2
);
  localparam int CW = $clog2(N_IN);

  logic                    io_mode;
  logic [N_IN-1:0]         io_in_valid;
  logic [N_IN-1:0]         io_in_ready;
  logic [N_IN*IDX_W-1:0]   io_in_bits_idx;
  logic [N_IN*WAY_W-1:0]   io_in_bits_way_en;
  logic [N_IN*TAG_W-1:0]   io_in_bits_tag;
  logic [N_IN*COH_W-1:0]   io_in_bits_data_coh_state;
  logic [N_IN*TAG_W-1:0]   io_in_bits_data_tag;
  logic                    io_out_ready;
  logic                    io_out_valid;
  logic [IDX_W-1:0]        io_out_bits_idx;
  logic [WAY_W-1:0]        io_out_bits_way_en;
  logic [TAG_W-1:0]        io_out_bits_tag;
  logic [COH_W-1:0]        io_out_bits_data_coh_state;
  logic [TAG_W-1:0]        io_out_bits_data_tag;
  logic [CW-1:0]           io_chosen;

  modport master (
    output io_mode, io_in_valid, io_in_bits_idx, io_in_bits_way_en, io_in_bits_tag,
           io_in_bits_data_coh_state, io_in_bits_data_tag, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en, io_out_bits_tag,
           io_out_bits_data_coh_state, io_out_bits_data_tag, io_chosen
  );

  modport slave (
    input  io_mode, io_in_valid, io_in_bits_idx, io_in_bits_way_en, io_in_bits_tag,
           io_in_bits_data_coh_state, io_in_bits_data_tag, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en, io_out_bits_tag,
           io_out_bits_data_coh_state, io_out_bits_data_tag, io_chosen
  );
endinterface

// File: rtl/rr_meta_arbiter.sv
// Fixed-priority / round-robin arbiter into a one-entry output register; 1-cycle latency.
// Backpressure: a held entry with io_out_ready=0 freezes outputs and drops every io_in_ready.
module rr_meta_arbiter #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 6,
  parameter int WAY_W = 4,
  parameter int TAG_W = 20,
  parameter int COH_W = 2
) (
  input logic              clock,
  input logic              reset,
  rr_meta_arbiter_if.slave io
);
  localparam int CW = $clog2(N_IN);

  logic [CW-1:0]    rr_ptr;
  logic [CW-1:0]    winner;
  logic [CW-1:0]    cand;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic             out_valid;
  logic [CW-1:0]    chosen;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] way_q;
  logic [TAG_W-1:0] tag_q;
  logic [COH_W-1:0] coh_q;
  logic [TAG_W-1:0] dtag_q;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      cand = io.io_mode ? CW'((int'(rr_ptr) + k) % N_IN) : CW'(k);
      if (!found && io.io_in_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign can_accept     = ~out_valid | io.io_out_ready;
  // Reset gates the grant so nothing is consumed while the block is held in reset.
  assign accept         = reset & found & can_accept;
  assign io.io_in_ready = accept ? (N_IN'(1) << winner) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      rr_ptr    <= '0;
      chosen    <= '0;
      idx_q     <= '0;
      way_q     <= '0;
      tag_q     <= '0;
      coh_q     <= '0;
      dtag_q    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      chosen    <= winner;
      idx_q     <= io.io_in_bits_idx[winner*IDX_W +: IDX_W];
      way_q     <= io.io_in_bits_way_en[winner*WAY_W +: WAY_W];
      tag_q     <= io.io_in_bits_tag[winner*TAG_W +: TAG_W];
      coh_q     <= io.io_in_bits_data_coh_state[winner*COH_W +: COH_W];
      dtag_q    <= io.io_in_bits_data_tag[winner*TAG_W +: TAG_W];
      if (io.io_mode)
        rr_ptr <= (winner == CW'(N_IN - 1)) ? '0 : winner + 1'b1;
    end else if (io.io_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign io.io_out_valid               = out_valid;
  assign io.io_chosen                  = chosen;
  assign io.io_out_bits_idx            = idx_q;
  assign io.io_out_bits_way_en         = way_q;
  assign io.io_out_bits_tag            = tag_q;
  assign io.io_out_bits_data_coh_state = coh_q;
  assign io.io_out_bits_data_tag       = dtag_q;
endmodule

// File: tb/tb_rr_meta_arbiter.sv
// Drives N_IN = 2, 4 and 8 arbiters from shared stimulus; a directed table targets the N_IN=4
// instance while a reference model checks every instance on every cycle.
module tb_rr_meta_arbiter;
  localparam int NS [3] = '{2, 4, 8};
  localparam int PW = 6 + 4 + 20 + 2 + 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         mode;
  logic         out_ready;
  logic [7:0]   in_valid;
  logic [47:0]  idx_v;
  logic [31:0]  way_v;
  logic [159:0] tag_v;
  logic [15:0]  coh_v;
  logic [159:0] dtag_v;

  logic [7:0]    rdy [3];
  logic          ov  [3];
  logic [2:0]    ch  [3];
  logic [PW-1:0] pay [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int N = NS[g];
    rr_meta_arbiter_if #(.N_IN(N)) bus ();
    rr_meta_arbiter #(.N_IN(N)) dut (.clock(clk), .reset(rst_n), .io(bus));
    assign bus.io_mode                   = mode;
    assign bus.io_out_ready              = out_ready;
    assign bus.io_in_valid               = in_valid[N-1:0];
    assign bus.io_in_bits_idx            = idx_v[N*6-1:0];
    assign bus.io_in_bits_way_en         = way_v[N*4-1:0];
    assign bus.io_in_bits_tag            = tag_v[N*20-1:0];
    assign bus.io_in_bits_data_coh_state = coh_v[N*2-1:0];
    assign bus.io_in_bits_data_tag       = dtag_v[N*20-1:0];
    assign rdy[g] = 8'(bus.io_in_ready);
    assign ov[g]  = bus.io_out_valid;
    assign ch[g]  = 3'(bus.io_chosen);
    assign pay[g] = {bus.io_out_bits_idx, bus.io_out_bits_way_en, bus.io_out_bits_tag,
                     bus.io_out_bits_data_coh_state, bus.io_out_bits_data_tag};
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the output register should hold and where the pointer stands.
  logic          m_ov  [3];
  logic [PW-1:0] m_pay [3];
  int            m_ch  [3];
  int            m_ptr [3];

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (N_IN=%0d) t=%0t: got %0h, want %0h", name, NS[g], $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] chan_pay(input int w);
    return {idx_v[w*6 +: 6], way_v[w*4 +: 4], tag_v[w*20 +: 20], coh_v[w*2 +: 2], dtag_v[w*20 +: 20]};
  endfunction

  // Fixed priority scans 0..n-1; round-robin scans ptr, ptr+1, ... wrapping at n.
  function automatic int pick(input int n, input logic md, input int ptr, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      int c;
      c = md ? (ptr + k) % n : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic rnd_pay();
    for (int i = 0; i < 8; i++) begin
      idx_v[i*6 +: 6]   = 6'($urandom);
      way_v[i*4 +: 4]   = 4'($urandom);
      tag_v[i*20 +: 20] = 20'($urandom);
      coh_v[i*2 +: 2]   = 2'($urandom);
      dtag_v[i*20 +: 20] = 20'($urandom);
    end
  endtask

  task automatic pre_edge();
    for (int g = 0; g < 3; g++) begin
      int n;
      int w;
      logic can;
      logic [7:0] er;
      n   = NS[g];
      w   = pick(n, mode, m_ptr[g], in_valid);
      can = !m_ov[g] || out_ready;
      er  = (rst_n && can && w >= 0) ? 8'(1 << w) : 8'h00;
      chk("in_ready", g, 64'(rdy[g]), 64'(er));
      if (!rst_n) begin
        m_ov[g] = 1'b0; m_pay[g] = '0; m_ch[g] = 0; m_ptr[g] = 0;
      end else if (er != 8'h00) begin
        m_ov[g] = 1'b1; m_pay[g] = chan_pay(w); m_ch[g] = w;
        if (mode) m_ptr[g] = (w + 1) % n;
      end else if (out_ready) begin
        m_ov[g] = 1'b0;
      end
    end
  endtask

  task automatic post_edge();
    for (int g = 0; g < 3; g++) begin
      chk("out_valid", g, 64'(ov[g]), 64'(m_ov[g]));
      chk("chosen", g, 64'(ch[g]), 64'(m_ch[g]));
      chk("payload", g, 64'(pay[g]), 64'(m_pay[g]));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       md;
    logic       ordy;
    logic [7:0] v;
    logic [3:0] rdy4;
    logic       ov4;
    int         ch4;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic rst, input logic md, input logic ordy, input logic [7:0] v,
                              input logic [3:0] r, input logic o, input int c);
    vec_t x;
    x.rst = rst; x.md = md; x.ordy = ordy; x.v = v; x.rdy4 = r; x.ov4 = o; x.ch4 = c;
    return x;
  endfunction

  initial begin
    for (int g = 0; g < 3; g++) begin
      m_ov[g] = 1'b0; m_pay[g] = '0; m_ch[g] = 0; m_ptr[g] = 0;
    end
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b0; in_valid = '0;
    rnd_pay();

    // Expectations below are for the N_IN=4 instance: ready seen this cycle, valid/chosen after the edge.
    tbl.push_back(mk(0, 0, 1, 8'b1010, 4'b0000, 0, 0));  // reset masks ready
    tbl.push_back(mk(0, 0, 1, 8'b0000, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 1, 8'b1010, 4'b0010, 1, 1));  // fixed priority picks ch 1
    tbl.push_back(mk(1, 0, 1, 8'b0000, 4'b0000, 0, 1));  // drain, chosen held
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0001, 1, 0));  // round-robin 0,1,2,3,0
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0010, 1, 1));
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0100, 1, 2));
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'b1111, 4'b0000, 1, 0));  // stalled three cycles
    tbl.push_back(mk(1, 1, 0, 8'b0110, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'b1001, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 1, 8'b0100, 4'b0100, 1, 2));  // drain + accept, no bubble
    tbl.push_back(mk(1, 1, 1, 8'b0010, 4'b0010, 1, 1));  // ptr -> 2
    tbl.push_back(mk(1, 1, 1, 8'b0011, 4'b0001, 1, 0));  // wraps to 0, ptr -> 1
    tbl.push_back(mk(1, 0, 1, 8'b0110, 4'b0010, 1, 1));  // mode 0, ptr holds 1
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0010, 1, 1));  // proves ptr stayed 1
    tbl.push_back(mk(0, 1, 1, 8'b1111, 4'b0000, 0, 0));  // reset drops held entry
    tbl.push_back(mk(1, 1, 1, 8'b1000, 4'b1000, 1, 3));
    tbl.push_back(mk(1, 1, 1, 8'b1111, 4'b0001, 1, 0));  // ptr was 0 after ch 3
    tbl.push_back(mk(1, 1, 0, 8'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 1, 1, 8'b0000, 4'b0000, 0, 0));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; mode = tbl[i].md; out_ready = tbl[i].ordy; in_valid = tbl[i].v;
      rnd_pay();
      #1;
      chk("tbl_ready", 1, 64'(rdy[1]), 64'(tbl[i].rdy4));
      pre_edge();
      @(posedge clk); #1;
      chk("tbl_out_valid", 1, 64'(ov[1]), 64'(tbl[i].ov4));
      chk("tbl_chosen", 1, 64'(ch[1]), 64'(tbl[i].ch4));
      post_edge();
    end

    // Held entry must not change its payload while stalled, whatever the inputs do.
    begin
      logic [PW-1:0] held;
      rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = 8'hFF; rnd_pay();
      #1; pre_edge(); @(posedge clk); #1; post_edge();
      held = pay[2];
      for (int k = 0; k < 3; k++) begin
        out_ready = 1'b0; in_valid = 8'($urandom); rnd_pay();
        #1; pre_edge(); @(posedge clk); #1; post_edge();
        chk("stall_hold", 2, 64'(pay[2]), 64'(held));
      end
    end

    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 40) != 0);
      mode      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rnd_pay();
      #1; pre_edge();
      @(posedge clk); #1; post_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
